// File: rtl/gpio_lut_writer.sv
// gpio_lut_writer: GPIO-bus master that programs a lookup_table target.
// Writes the start address (high byte, then low byte) to ADDR_REG, then for
// every accepted word writes its high byte and then its low byte to DATA_REG.
// The target commits each word and auto-increments its address by itself.
// Each bus write is SETUP (1 cycle), w_clk HIGH (HOLD_CYCLES), w_clk LOW (HOLD_CYCLES).
// Optional feature: define GPIO_LUT_WRITER_CHECKSUM_EN to add the checksum output.
module gpio_lut_writer #(
  parameter int ADDR_REG       = 0,
  parameter int DATA_REG       = 1,
  parameter int WORD_BITS      = 16,
  parameter int HOLD_CYCLES    = 2,
  // GPIO field placement (w_clk bit, register-address field, 8-bit data field)
  parameter int GPIO_W_CLK_BIT = 0,
  parameter int GPIO_ADDR_LSB  = 8,
  parameter int GPIO_ADDR_BITS = 8,
  parameter int GPIO_DATA_LSB  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          start_addr,
  input  logic [WORD_BITS-1:0] word_in,
  input  logic                 word_valid,
  input  logic                 word_last,
  output logic                 word_ready,
  output logic [31:0]          gpio_out,
  output logic                 busy,
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
  output logic [15:0]          checksum,
`endif
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, WAIT_WORD, DATA_HI, DATA_LO, DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_LOW} phase_t;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg, state_next;
  phase_t           phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      addr_reg, addr_next;
  logic [15:0]      word_reg, word_next;
  logic             last_reg, last_next;
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
  logic [15:0]      checksum_reg, checksum_next;
`endif

  logic [15:0] word_ext;
  logic        in_write;
  logic        write_done;

  // Zero-extend the incoming word to the 16-bit LUT entry width
  for (genvar gi = 0; gi < 16; gi++) begin : g_word_ext
    if (gi < WORD_BITS) begin : g_used
      assign word_ext[gi] = word_in[gi];
    end else begin : g_zero
      assign word_ext[gi] = 1'b0;
    end
  end

  assign in_write   = (state_reg == ADDR_HI) || (state_reg == ADDR_LO) ||
                      (state_reg == DATA_HI) || (state_reg == DATA_LO);
  assign write_done = (phase_reg == PH_LOW) && (cnt_reg == CNT_LAST);

  assign word_ready = (state_reg == WAIT_WORD);
  assign busy       = (state_reg != IDLE) && (state_reg != DONE);
  assign done       = (state_reg == DONE);
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
  assign checksum   = checksum_reg;
`endif

  // State and datapath registers; async reset drops w_clk immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      phase_reg    <= PH_SETUP;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      word_reg     <= '0;
      last_reg     <= 1'b0;
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
      checksum_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      word_reg     <= word_next;
      last_reg     <= last_next;
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
      checksum_reg <= checksum_next;
`endif
    end
  end

  // Next-state: bus-write phase sequencing plus load-level state machine
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    word_next     = word_reg;
    last_next     = last_reg;
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
    checksum_next = checksum_reg;
`endif

    if (in_write) begin
      case (phase_reg)
        PH_SETUP: begin
          phase_next = PH_HIGH;
          cnt_next   = '0;
        end
        PH_HIGH: begin
          if (cnt_reg == CNT_LAST) begin
            phase_next = PH_LOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        PH_LOW: begin
          if (cnt_reg == CNT_LAST) begin
            phase_next = PH_SETUP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          phase_next = PH_SETUP;
          cnt_next   = '0;
        end
      endcase
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next     = start_addr;
          state_next    = ADDR_HI;
          phase_next    = PH_SETUP;
          cnt_next      = '0;
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
          checksum_next = '0;
`endif
        end
      end
      ADDR_HI: if (write_done) state_next = ADDR_LO;
      ADDR_LO: if (write_done) state_next = WAIT_WORD;
      WAIT_WORD: begin
        if (word_valid) begin
          word_next     = word_ext;
          last_next     = word_last;
          state_next    = DATA_HI;
          phase_next    = PH_SETUP;
          cnt_next      = '0;
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
          checksum_next = checksum_reg + word_ext;
`endif
        end
      end
      DATA_HI: if (write_done) state_next = DATA_LO;
      DATA_LO: if (write_done) state_next = last_reg ? DONE : WAIT_WORD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // GPIO word: register select, data byte and w_clk only while a write is in progress
  always_comb begin
    logic [7:0] byte_sel;
    logic       to_addr_reg;
    gpio_out    = '0;
    byte_sel    = 8'h00;
    to_addr_reg = (state_reg == ADDR_HI) || (state_reg == ADDR_LO);
    case (state_reg)
      ADDR_HI: byte_sel = addr_reg[15:8];
      ADDR_LO: byte_sel = addr_reg[7:0];
      DATA_HI: byte_sel = word_reg[15:8];
      DATA_LO: byte_sel = word_reg[7:0];
      default: byte_sel = 8'h00;
    endcase
    if (in_write) begin
      gpio_out[GPIO_ADDR_LSB +: GPIO_ADDR_BITS] =
        to_addr_reg ? GPIO_ADDR_BITS'(ADDR_REG) : GPIO_ADDR_BITS'(DATA_REG);
      gpio_out[GPIO_DATA_LSB +: 8]  = byte_sel;
      gpio_out[GPIO_W_CLK_BIT]      = (phase_reg == PH_HIGH);
    end
  end

endmodule

// File: tb/tb_gpio_lut_writer.sv
// tb_gpio_lut_writer: scoreboard bench for gpio_lut_writer.
// Stimulus pushes expected bus writes (register, byte) into a queue; a monitor
// pops one per rising w_clk, checks phase lengths/stability and feeds a small
// lookup_table target model whose memory is then checked against hand values.
module tb_gpio_lut_writer;
  localparam int HOLD      = 2;
  localparam int ADDR_REG  = 0;
  localparam int DATA_REG  = 1;
  localparam int W_CLK_BIT = 0;
  localparam int ADDR_LSB  = 8;
  localparam int DATA_LSB  = 16;
  localparam logic [31:0] USED = (32'hFF << ADDR_LSB) | (32'hFF << DATA_LSB) | (32'h1 << W_CLK_BIT);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_last = 1'b0;
  logic        word_ready;
  logic [31:0] gpio_out;
  logic        busy;
  logic        done;
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  gpio_lut_writer #(.HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .gpio_out   (gpio_out),
    .busy       (busy),
`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int lut_bits = 16;
  logic [15:0] exp_q[$];
  logic [15:0] lut_mem [0:65535];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Monitor: bus-write decode, phase checks, scoreboard pop, target model
  logic        prev_wclk = 1'b0;
  logic [15:0] prev_f = '0;
  logic [15:0] cap_f = '0;
  int high_cnt = 0, low_left = 0, cycle = 0, last_rise = 0, addr_cnt = 0, data_cnt = 0;
  logic [15:0] tgt_addr = '0;
  logic        tgt_phase = 1'b0;
  logic [7:0]  tgt_hi = '0;

  always @(negedge clk) begin
    logic        wclk;
    logic [15:0] f;
    logic [15:0] e;
    int          mask;
    cycle++;
    if (!rst) begin
      prev_wclk = 1'b0; prev_f = '0; high_cnt = 0; low_left = 0;
      addr_cnt = 0; data_cnt = 0; tgt_phase = 1'b0;
    end else begin
      if (done) done_cnt++;
      wclk = gpio_out[W_CLK_BIT];
      f    = {gpio_out[ADDR_LSB +: 8], gpio_out[DATA_LSB +: 8]};
      mask = (1 << lut_bits) - 1;
      if (wclk && !prev_wclk) begin
        check("setup_stable", {16'h0, prev_f}, {16'h0, f});
        check("unused_zero", gpio_out & ~USED, 32'h0);
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected_write reg=%0d data=0x%02h", f[15:8], f[7:0]));
        end else begin
          e = exp_q.pop_front();
          check("bus_write", {16'h0, f}, {16'h0, e});
        end
        if (f[15:8] == 8'(ADDR_REG)) begin
          if (addr_cnt % 2 == 1) check("addr_gap", cycle - last_rise, 1 + 2 * HOLD);
          addr_cnt++;
          tgt_addr = {tgt_addr[7:0], f[7:0]};
        end else if (f[15:8] == 8'(DATA_REG)) begin
          if (data_cnt % 2 == 1) check("data_gap", cycle - last_rise, 1 + 2 * HOLD);
          data_cnt++;
          if (!tgt_phase) begin
            tgt_hi = f[7:0];
            tgt_phase = 1'b1;
          end else begin
            lut_mem[int'(tgt_addr) & mask] = {tgt_hi, f[7:0]};
            tgt_addr = 16'((int'(tgt_addr) + 1) & mask);
            tgt_phase = 1'b0;
          end
        end
        $display("[%0t] bus write reg=%0d data=0x%02h", $time, f[15:8], f[7:0]);
        cap_f = f;
        high_cnt = 1;
        last_rise = cycle;
      end else if (wclk && prev_wclk) begin
        high_cnt++;
        check("high_stable", {16'h0, f}, {16'h0, cap_f});
      end else if (!wclk && prev_wclk) begin
        check("high_len", high_cnt, HOLD);
        check("low_stable", {16'h0, f}, {16'h0, cap_f});
        low_left = HOLD - 1;
      end else if (low_left > 0) begin
        check("low_stable", {16'h0, f}, {16'h0, cap_f});
        low_left--;
      end
      prev_wclk = wclk;
      prev_f = f;
    end
  end

  task automatic start_load(input logic [15:0] a);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    exp_q.push_back({8'(ADDR_REG), a[15:8]});
    exp_q.push_back({8'(ADDR_REG), a[7:0]});
    exp_done++;
    $display("[%0t] start load addr=0x%04h", $time, a);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Offer one word; sparse offers valid on one cycle out of three
  task automatic send_word(input logic [15:0] w, input logic last, input bit sparse);
    int waited = 0;
    bit acc = 0;
    word_in = w;
    word_last = last;
    while (!acc && waited < 500) begin
      word_valid = 1'b1;
      if (word_ready) begin
        acc = 1;
        exp_q.push_back({8'(DATA_REG), w[15:8]});
        exp_q.push_back({8'(DATA_REG), w[7:0]});
      end
      @(negedge clk);
      waited++;
      if (sparse) begin
        word_valid = 1'b0;
        if (!acc) begin
          @(negedge clk);
          @(negedge clk);
          waited += 2;
        end
      end
    end
    word_valid = 1'b0;
    if (!acc) fail_now("word_accept_timeout");
    else begin
      $display("[%0t] word 0x%04h last=%0d accepted", $time, w, last);
      check("ready_after_accept", word_ready, 0);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("done_timeout");
    else check("busy_at_done", busy, 0);
    @(negedge clk);
    #1;
    check("done_count", done_cnt, exp_done);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad_gpio, bad_busy, bad_ready, bad_done;
    int n;
    // Reset held, then 20 idle cycles
    repeat (3) @(negedge clk);
    check("rst_gpio", gpio_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", word_ready, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    bad_gpio = 0; bad_busy = 0; bad_ready = 0; bad_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (gpio_out != 0) bad_gpio = 1;
      if (busy) bad_busy = 1;
      if (word_ready) bad_ready = 1;
      if (done) bad_done = 1;
    end
    check("idle_gpio", bad_gpio, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_ready", bad_ready, 0);
    check("idle_done", bad_done, 0);

    // Single word load
    lut_bits = 16;
    start_load(16'h1234);
    send_word(16'hBEEF, 1'b1, 1'b0);
    wait_done();
    check("mem_1234", lut_mem[16'h1234], 16'hBEEF);

    // Four words with address wrap on an 8-bit target
    lut_bits = 8;
    start_load(16'h00FE);
    send_word(16'h0001, 1'b0, 1'b0);
    send_word(16'h0002, 1'b0, 1'b0);
    send_word(16'h0003, 1'b0, 1'b0);
    send_word(16'h0004, 1'b1, 1'b0);
    wait_done();
    check("mem_FE", lut_mem[8'hFE], 16'h0001);
    check("mem_FF", lut_mem[8'hFF], 16'h0002);
    check("mem_00", lut_mem[8'h00], 16'h0003);
    check("mem_01", lut_mem[8'h01], 16'h0004);

    // Sparse valid, order kept
    lut_bits = 16;
    start_load(16'h0100);
    send_word(16'h1111, 1'b0, 1'b1);
    send_word(16'h2222, 1'b0, 1'b1);
    send_word(16'h3333, 1'b1, 1'b1);
    wait_done();
    check("mem_0100", lut_mem[16'h0100], 16'h1111);
    check("mem_0101", lut_mem[16'h0101], 16'h2222);
    check("mem_0102", lut_mem[16'h0102], 16'h3333);

    // start while busy and on the done cycle is ignored
    start_load(16'h0200);
    start = 1'b1; start_addr = 16'h0300;
    @(negedge clk);
    start = 1'b0;
    send_word(16'hAAAA, 1'b0, 1'b0);
    send_word(16'h5555, 1'b1, 1'b0);
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("done_timeout_restart");
    check("busy_on_done", busy, 0);
    start = 1'b1; start_addr = 16'h0400;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("restart_ignored_busy", busy, 0);
    check("restart_done_count", done_cnt, exp_done);
    check("restart_queue", exp_q.size(), 0);
    check("mem_0200", lut_mem[16'h0200], 16'hAAAA);
    check("mem_0201", lut_mem[16'h0201], 16'h5555);

    // Reset during the DATA_HI high phase
    start_load(16'h0040);
    send_word(16'h1357, 1'b1, 1'b0);
    n = 0;
    while (!(gpio_out[W_CLK_BIT] && gpio_out[ADDR_LSB +: 8] == 8'(DATA_REG)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("data_hi_timeout");
    #1 rst = 1'b0;
    #1;
    check("midload_rst_gpio", gpio_out, 0);
    check("midload_rst_busy", busy, 0);
    exp_q.delete();
    exp_done--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_load(16'h0010);
    send_word(16'hA5C3, 1'b1, 1'b0);
    wait_done();
    check("mem_0010", lut_mem[16'h0010], 16'hA5C3);

`ifdef GPIO_LUT_WRITER_CHECKSUM_EN
    start_load(16'h0500);
    check("checksum_cleared", checksum, 0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    send_word(16'h0002, 1'b1, 1'b0);
    wait_done();
    check("checksum", checksum, 16'h0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
